// File: rtl/axis_pkg.sv
// Shared helpers for the FIFO-path stream blocks.
// Width helpers, saturation limits and stats counter width.
package axis_pkg;

   localparam int CNT_W = 16;

   function automatic int axis_in_width(input int var_width, input int mul_factor);
      return var_width + mul_factor - 1;
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: output register O plus skid register S.
// Ready is registered and drops only while S holds a beat.
module axis_skid_buffer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic [WIDTH-1:0] o_data, o_data_nx;
   logic [WIDTH-1:0] k_data, k_data_nx;
   logic             o_vld, o_vld_nx;
   logic             k_vld, k_vld_nx;
   logic             rdy;
   logic             accept, emit;

   assign accept  = s_valid && rdy;
   assign emit    = o_vld && m_ready;
   assign s_ready = rdy;
   assign m_data  = o_data;
   assign m_valid = o_vld;

   // next-state of O and S; ready is only high when S is empty
   always_comb begin
      o_data_nx = o_data;
      k_data_nx = k_data;
      o_vld_nx  = o_vld;
      k_vld_nx  = k_vld;
      if (k_vld) begin
         if (emit) begin
            o_data_nx = k_data;
            k_vld_nx  = 1'b0;
         end
      end else if (accept) begin
         if (!o_vld || emit) begin
            o_data_nx = s_data;
            o_vld_nx  = 1'b1;
         end else begin
            k_data_nx = s_data;
            k_vld_nx  = 1'b1;
         end
      end else if (emit) begin
         o_vld_nx = 1'b0;
      end
   end

   // storage and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data <= '0;
         k_data <= '0;
         o_vld  <= 1'b0;
         k_vld  <= 1'b0;
         rdy    <= 1'b0;
      end else begin
         o_data <= o_data_nx;
         k_data <= k_data_nx;
         o_vld  <= o_vld_nx;
         k_vld  <= k_vld_nx;
         rdy    <= !k_vld_nx;
      end
   end

endmodule

// File: rtl/axis_narrow_sat.sv
// Narrows the widened stream: round, arithmetic shift, saturate.
// Keeps sticky saturation statistics counted at accept time.
module axis_narrow_sat
   import axis_pkg::*;
#(
   parameter  int VAR_WIDTH  = 16,
   parameter  int MUL_FACTOR = 2,
   parameter  int SHIFT      = 0,
   localparam int IN_W       = axis_in_width(VAR_WIDTH, MUL_FACTOR)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IN_W-1:0]      s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [VAR_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic                 clr_stats,
   output logic [CNT_W-1:0]     sat_cnt,
   output logic                 sat_flag
);

   if (SHIFT < 0 || SHIFT >= MUL_FACTOR) begin : g_bad_shift
      $error("axis_narrow_sat: SHIFT out of range");
   end

   localparam int RND = (1 << SHIFT) >> 1;
   localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(sat_max(VAR_WIDTH));
   localparam logic signed [IN_W:0] MINV = (IN_W+1)'(sat_min(VAR_WIDTH));

   logic signed [IN_W:0]  ext, sum, q;
   logic                  hi, lo;
   logic [VAR_WIDTH-1:0]  nar;
   logic                  sat_ev;

   // round half toward +inf, shift, clamp to the output range
   always_comb begin
      ext = $signed({s_axis_tdata[IN_W-1], s_axis_tdata});
      sum = ext + (IN_W+1)'(RND);
      q   = sum >>> SHIFT;
      hi  = q > MAXV;
      lo  = q < MINV;
      nar = q[VAR_WIDTH-1:0];
      if (hi) begin
         nar = MAXV[VAR_WIDTH-1:0];
      end else if (lo) begin
         nar = MINV[VAR_WIDTH-1:0];
      end
   end

   axis_skid_buffer #(
      .WIDTH (VAR_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (nar),
      .s_valid (s_axis_tvalid),
      .s_ready (s_axis_tready),
      .m_data  (m_axis_tdata),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   assign sat_ev = s_axis_tvalid && s_axis_tready && (hi || lo);

   // sticky stats; clear wins over a coincident event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt  <= '0;
         sat_flag <= 1'b0;
      end else if (clr_stats) begin
         sat_cnt  <= '0;
         sat_flag <= 1'b0;
      end else if (sat_ev) begin
         sat_flag <= 1'b1;
         if (sat_cnt != '1) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axis_narrow_sat.sv
// Randomized self-checking bench for axis_narrow_sat.
// Two instances (SHIFT 0 and 1) share all inputs.
module tb_axis_narrow_sat;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [16:0] tdata = '0;
   logic        tvalid = 1'b0;
   logic        m_ready = 1'b0;
   logic        clr = 1'b0;

   logic        rdy0, rdy1, mv0, mv1, fl0, fl1;
   logic [15:0] md0, md1, cnt0, cnt1;

   int total = 0;
   int bad = 0;
   logic [15:0] exp0[$], exp1[$], got0[$], got1[$];
   logic last_acc;

   always #5 clk = ~clk;

   axis_narrow_sat #(.VAR_WIDTH(16), .MUL_FACTOR(2), .SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy0),
      .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(m_ready),
      .clr_stats(clr), .sat_cnt(cnt0), .sat_flag(fl0)
   );

   axis_narrow_sat #(.VAR_WIDTH(16), .MUL_FACTOR(2), .SHIFT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy1),
      .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(m_ready),
      .clr_stats(clr), .sat_cnt(cnt1), .sat_flag(fl1)
   );

   // value = clamp(floor((x + 2^sh/2) / 2^sh))
   function automatic longint ideal(input logic [16:0] x, input int sh);
      longint v;
      v = longint'($signed(x)) + ((longint'(1) << sh) / 2);
      return v >>> sh;
   endfunction

   function automatic logic [15:0] model(input logic [16:0] x, input int sh);
      longint v;
      v = ideal(x, sh);
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v[15:0];
   endfunction

   function automatic bit is_sat(input logic [16:0] x, input int sh);
      longint v;
      v = ideal(x, sh);
      return (v > 32767) || (v < -32768);
   endfunction

   task automatic cycle();
      last_acc = tvalid && rdy0;
      if (last_acc) begin
         exp0.push_back(model(tdata, 0));
         exp1.push_back(model(tdata, 1));
      end
      if (mv0 && m_ready) got0.push_back(md0);
      if (mv1 && m_ready) got1.push_back(md1);
      @(posedge clk);
      #1;
   endtask

   task automatic flush_q();
      exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
   endtask

   task automatic drain(input int n);
      tvalid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (rdy0 !== 1'b0 || mv0 !== 1'b0 || md0 !== 16'h0) begin
         bad++;
         $display("FAIL reset_out: rdy=%b vld=%b data=%h need 0 0 0000", rdy0, mv0, md0);
      end
      total++;
      if (cnt0 !== 16'h0 || fl0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_stats: cnt=%h flag=%b need 0000 0", cnt0, fl0);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (rdy0 !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready_rise: got %b need 1", rdy0);
      end
   endtask

   task automatic test_rounding();
      logic [16:0] vec [2];
      flush_q();
      vec[0] = 17'd3;
      vec[1] = 17'h1FFFD;
      m_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tdata = vec[i];
         tvalid = 1'b1;
         cycle();
      end
      drain(3);
      total++;
      if (got1.size() != 2) begin
         bad++;
         $display("FAIL round_count: got %0d need 2", got1.size());
      end else begin
         total++;
         if (got1[0] !== 16'h0002) begin
            bad++;
            $display("FAIL round_pos: got %h need 0002", got1[0]);
         end
         total++;
         if (got1[1] !== 16'hFFFF) begin
            bad++;
            $display("FAIL round_neg: got %h need ffff", got1[1]);
         end
      end
      total++;
      if (cnt1 !== 16'h0) begin
         bad++;
         $display("FAIL round_satcnt: got %h need 0000", cnt1);
      end
   endtask

   task automatic test_saturation();
      logic [16:0] vec [3];
      logic [15:0] want [3];
      flush_q();
      vec[0] = 17'h08000; want[0] = 16'h7FFF;
      vec[1] = 17'h17FFF; want[1] = 16'h8000;
      vec[2] = 17'h07FFF; want[2] = 16'h7FFF;
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tdata = vec[i];
         tvalid = 1'b1;
         cycle();
      end
      drain(3);
      total++;
      if (got0.size() != 3) begin
         bad++;
         $display("FAIL sat_count_out: got %0d need 3", got0.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (got0[i] !== want[i]) begin
               bad++;
               $display("FAIL sat_val%0d: got %h need %h", i, got0[i], want[i]);
            end
         end
      end
      total++;
      if (cnt0 !== 16'd2 || fl0 !== 1'b1) begin
         bad++;
         $display("FAIL sat_stats: cnt=%h flag=%b need 0002 1", cnt0, fl0);
      end
   endtask

   task automatic test_backpressure();
      int nxt, acc;
      flush_q();
      m_ready = 1'b0;
      nxt = 1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         tdata = 17'(nxt);
         tvalid = (nxt <= 4);
         cycle();
         if (last_acc) begin
            nxt++;
            acc++;
         end
         if (c == 1) begin
            total++;
            if (rdy0 !== 1'b0) begin
               bad++;
               $display("FAIL bp_ready_drop: got %b need 0", rdy0);
            end
         end
      end
      total++;
      if (acc != 2) begin
         bad++;
         $display("FAIL bp_accepts: got %0d need 2", acc);
      end
      total++;
      if (mv0 !== 1'b1 || md0 !== 16'd1) begin
         bad++;
         $display("FAIL bp_hold: vld=%b data=%h need 1 0001", mv0, md0);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 20 && nxt <= 4; c++) begin
         tdata = 17'(nxt);
         tvalid = 1'b1;
         cycle();
         if (last_acc) nxt++;
      end
      drain(4);
      total++;
      if (got0.size() != 4) begin
         bad++;
         $display("FAIL bp_out_count: got %0d need 4", got0.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (got0[i] !== 16'(i + 1)) begin
               bad++;
               $display("FAIL bp_order%0d: got %h need %h", i, got0[i], 16'(i + 1));
            end
         end
      end
   endtask

   task automatic test_throughput();
      int acc, first, last, n;
      flush_q();
      m_ready = 1'b1;
      acc = 0;
      first = -1;
      last = -1;
      for (int c = 0; c < 102; c++) begin
         n = got0.size();
         tvalid = (c < 100);
         tdata = 17'($urandom);
         cycle();
         if (last_acc) acc++;
         if (got0.size() != n) begin
            if (first < 0) first = c;
            last = c;
         end
      end
      total++;
      if (acc != 100) begin
         bad++;
         $display("FAIL tp_accepts: got %0d need 100", acc);
      end
      total++;
      if (got0.size() != 100 || first != 1 || last != 100) begin
         bad++;
         $display("FAIL tp_timing: n=%0d first=%0d last=%0d need 100 1 100", got0.size(), first, last);
      end
      total++;
      if (got0 != exp0 || got1 != exp1) begin
         bad++;
         $display("FAIL tp_data: sizes %0d/%0d need %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size());
      end
   endtask

   task automatic test_random_stall();
      int errs;
      flush_q();
      for (int c = 0; c < 400; c++) begin
         tvalid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         if (!(tvalid && rdy0)) tdata = tdata;
         tdata = 17'($urandom);
         cycle();
      end
      drain(4);
      total++;
      if (got0.size() != exp0.size()) begin
         bad++;
         $display("FAIL rnd_count: got %0d need %0d", got0.size(), exp0.size());
      end else begin
         errs = 0;
         for (int i = 0; i < got0.size(); i++) begin
            if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) errs++;
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL rnd_data: %0d beats differ, need 0", errs);
         end
      end
   endtask

   task automatic test_stats();
      int model_cnt;
      flush_q();
      clr = 1'b1;
      drain(1);
      clr = 1'b0;
      m_ready = 1'b1;
      tvalid = 1'b1;
      model_cnt = 0;
      for (int i = 0; i < 65537; i++) begin
         tdata = ($urandom_range(0, 1) != 0) ? 17'h08000 : 17'h17FFE;
         cycle();
         if (last_acc && is_sat(tdata, 0) && model_cnt < 65535) model_cnt++;
         if (got0.size() > 8) flush_q();
      end
      tvalid = 1'b0;
      total++;
      if (cnt0 !== 16'(model_cnt) || cnt0 !== 16'hFFFF || fl0 !== 1'b1) begin
         bad++;
         $display("FAIL stats_stick: cnt=%h flag=%b need ffff 1", cnt0, fl0);
      end
      tdata = 17'h08000;
      tvalid = 1'b1;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      tvalid = 1'b0;
      total++;
      if (cnt0 !== 16'h0 || fl0 !== 1'b0) begin
         bad++;
         $display("FAIL stats_clr_wins: cnt=%h flag=%b need 0000 0", cnt0, fl0);
      end
      tvalid = 1'b1;
      cycle();
      tvalid = 1'b0;
      total++;
      if (cnt0 !== 16'd1 || fl0 !== 1'b1) begin
         bad++;
         $display("FAIL stats_after_clr: cnt=%h flag=%b need 0001 1", cnt0, fl0);
      end
      drain(3);
   endtask

   task automatic test_mid_reset();
      flush_q();
      m_ready = 1'b0;
      tvalid = 1'b1;
      tdata = 17'd11;
      cycle();
      tdata = 17'd12;
      cycle();
      tvalid = 1'b0;
      cycle();
      total++;
      if (rdy0 !== 1'b0 || mv0 !== 1'b1) begin
         bad++;
         $display("FAIL mr_full: rdy=%b vld=%b need 0 1", rdy0, mv0);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (mv0 !== 1'b0 || md0 !== 16'h0 || rdy0 !== 1'b0 || cnt0 !== 16'h0) begin
         bad++;
         $display("FAIL mr_async: vld=%b data=%h rdy=%b cnt=%h need 0 0000 0 0000", mv0, md0, rdy0, cnt0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (rdy0 !== 1'b1) begin
         bad++;
         $display("FAIL mr_ready: got %b need 1", rdy0);
      end
      flush_q();
      drain(5);
      total++;
      if (got0.size() != 0) begin
         bad++;
         $display("FAIL mr_stale: got %0d beats need 0", got0.size());
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_throughput();
      test_random_stall();
      test_stats();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_narrow_sat.md
# axis_narrow_sat

Stream-side width reducer at the output of the FIFO datapath. It accepts the widened AXI-Stream output beat (VAR_WIDTH + MUL_FACTOR − 1 bits, signed), applies an arithmetic right shift with rounding, saturates the result to VAR_WIDTH bits and re-emits it on a VAR_WIDTH AXI-Stream master. A two-entry skid buffer gives full throughput with a registered s_axis_tready, and sticky saturation statistics are provided for software.

## Interface
- VAR_WIDTH, 16, output sample width; signed two's complement.
- MUL_FACTOR, 2, growth factor of the upstream stream; input width IN_W = VAR_WIDTH + MUL_FACTOR − 1.
- SHIFT, 0, right-shift amount, legal range 0..MUL_FACTOR−1; out-of-range values are an elaboration error.
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  IN_W  signed input sample.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready; driven directly from a flop.
- m_axis_tdata  out  VAR_WIDTH  reduced, saturated sample.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- clr_stats  in  1  synchronous clear of sat_cnt and sat_flag.
- sat_cnt  out  16  number of accepted beats that saturated; sticks at 16'hFFFF.
- sat_flag  out  1  sticky: set on any saturated beat.

## Operation
- Accept on s_axis_tvalid && s_axis_tready; emit on m_axis_tvalid && m_axis_tready.
- Arithmetic, in IN_W+1 bits signed: sum = tdata + (SHIFT>0 ? 2^(SHIFT−1) : 0); q = sum >>> SHIFT (round half toward +inf).
- Saturation: q > 2^(VAR_WIDTH−1)−1 → 2^(VAR_WIDTH−1)−1; q < −2^(VAR_WIDTH−1) → −2^(VAR_WIDTH−1); otherwise low VAR_WIDTH bits of q. Either clamp is a sat event.
- Storage: output register O (drives m_axis_*) and skid register S. Each accepted beat goes to O if O is empty or being emitted this cycle and S is empty; otherwise it goes to S. When O is emitted and S is valid, S moves into O in the same edge.
- s_axis_tready next = !S_valid_next. Input is never dropped; output order equals input order.
- m_axis_tdata/tvalid stay stable while m_axis_tvalid && !m_axis_tready (AXI-Stream rule).
- Stats: sat event counted at accept time. sat_cnt += 1 unless already 16'hFFFF. clr_stats in the same cycle as a sat event wins: sat_cnt = 0, sat_flag = 0.

## Timing
- Reset values: s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0, sat_cnt 0, sat_flag 0, O/S valid 0.
- s_axis_tready rises on the first clk edge after rst_n deasserts.
- Latency: beat accepted at edge N appears on m_axis at edge N (visible in cycle N+1); 1 cycle.
- Throughput: 1 beat/cycle with m_axis_tready held high.
- Backpressure: with m_axis_tready low, two beats can be absorbed (O, S); s_axis_tready drops the cycle after S fills and rises the cycle after S drains.
- Simultaneous accept and emit with S empty: new beat replaces O; S stays empty.
- Reset asserted mid-stream: all buffered beats discarded immediately (asynchronous); outputs return to reset values.

## Structure
- Shared package axis_pkg: function axis_in_width(VAR_WIDTH, MUL_FACTOR), saturation limit helpers sat_max/sat_min, and the 16-bit counter width constant.
- One sub-module: axis_skid_buffer (parameter WIDTH; O/S registers and registered ready), reusable by other FIFO-path blocks. Rounding/saturation stays in the top as combinational logic before the buffer.

## Test plan
- Rounding: VAR_WIDTH=16, MUL_FACTOR=2, SHIFT=1; inputs 17'd3, −3 (17'h1FFFD) → outputs 16'h0002, 16'hFFFF; sat_cnt 0.
- Saturation: SHIFT=0; inputs 17'h08000, 17'h17FFF, 17'h07FFF → 16'h7FFF, 16'h8000, 16'h7FFF; sat_cnt 2, sat_flag 1.
- Backpressure: m_axis_tready low, drive 4 beats 1..4 → exactly 2 accepted, s_axis_tready 0 from the cycle after the 2nd accept; release tready → 1,2,3,4 emitted in order, no loss/duplication.
- Full throughput: 100 random beats, tready high → 100 outputs in 100 consecutive cycles after 1-cycle latency, values match model.
- Stats: force 65537 sat events → sat_cnt 16'hFFFF; clr_stats coincident with sat event → sat_cnt 0, sat_flag 0.
- Reset mid-operation: assert rst_n low with O and S full → m_axis_tvalid 0 immediately; after release no stale beat emitted, s_axis_tready 1 after first edge.
